// File: rtl/seg7_pkg.sv
// Shared constants, decode table and types for the seven-segment scan controller.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} pattern for each hex nibble 0..F.
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // One complete display image: four nibbles, decimal points and enables.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
  } disp_t;

  // Phase inside a digit slot.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display request/pin bundle between user logic (master) and the scan controller (slave).
interface seg7_scan_ctrl_if;

  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  en;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  modport master (
    output value, dp_in, en, load,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  value, dp_in, en, load,
    output seg, dp, an, frame_tick
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup.
  always_comb begin
    seg_c = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scanner with double-buffered display image.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned BLANK   = 1000
) (
  input  logic             clock,
  input  logic             reset,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  disp_t            pend_q, pend_nxt;
  logic             pend_vld_q, pend_vld_nxt;
  disp_t            shadow_q, shadow_nxt;
  disp_t            ld;
  logic             slot_end, frame_end;

  logic [SEG_W-1:0]      seg_q, seg_nxt;
  logic                  dp_q, dp_nxt;
  logic [NUM_DIGITS-1:0] an_q, an_nxt;
  logic                  tick_q, tick_nxt;
  logic [3:0]            nibble;
  logic [SEG_W-1:0]      dec_seg;
  phase_t                phase;

  // Slot counter, digit index and pending/shadow buffer update.
  always_comb begin
    cnt_nxt      = cnt_q + CW'(1);
    idx_nxt      = idx_q;
    pend_nxt     = pend_q;
    pend_vld_nxt = pend_vld_q;
    shadow_nxt   = shadow_q;
    ld           = '{value: bus.value, dp: bus.dp_in, en: bus.en};
    slot_end     = (cnt_q == CW'(CLK_DIV - 1));
    frame_end    = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

    if (slot_end) begin
      cnt_nxt = '0;
      idx_nxt = idx_q + IDX_W'(1);
    end

    // A load coinciding with the frame edge skips the pending stage entirely.
    if (frame_end) begin
      if (bus.load) begin
        shadow_nxt = ld;
      end else if (pend_vld_q) begin
        shadow_nxt = pend_q;
      end
      pend_vld_nxt = 1'b0;
    end else if (bus.load) begin
      pend_nxt     = ld;
      pend_vld_nxt = 1'b1;
    end
  end

  assign nibble = shadow_nxt.value[{idx_nxt, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg_c  (dec_seg)
  );

  // Pin values for the upcoming cycle, so registered outputs align with cnt/idx.
  always_comb begin
    seg_nxt  = SEG_OFF;
    dp_nxt   = 1'b1;
    an_nxt   = AN_OFF;
    phase    = (cnt_nxt < CW'(BLANK)) ? PH_BLANK : PH_DRIVE;
    tick_nxt = (idx_nxt == IDX_W'(NUM_DIGITS - 1)) && (cnt_nxt == CW'(CLK_DIV - 1));

    if (phase == PH_DRIVE && shadow_nxt.en[idx_nxt]) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = dec_seg;
      dp_nxt  = ~shadow_nxt.dp[idx_nxt];
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      shadow_q   <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= AN_OFF;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_nxt;
      idx_q      <= idx_nxt;
      pend_q     <= pend_nxt;
      pend_vld_q <= pend_vld_nxt;
      shadow_q   <= shadow_nxt;
      seg_q      <= seg_nxt;
      dp_q       <= dp_nxt;
      an_q       <= an_nxt;
      tick_q     <= tick_nxt;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with CLK_DIV=8, BLANK=2.
module tb_seg7_scan_ctrl;

  logic clock;
  logic reset;
  int   cyc;
  int   epoch;
  int   checks;
  int   passes;
  int   onehot_viol;
  int   mask_viol;
  logic prev_tick;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  localparam logic [6:0] S_OFF = 7'b1111111;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(.CLK_DIV(8), .BLANK(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Clocks elapsed since reset release.
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, req);
    else passes++;
  endtask

  task automatic exp_at(input int c, input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_t x;
    x.cyc = c; x.an = a; x.seg = s; x.dp = d;
    sb.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic load_at(input int n, input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
    wait_cyc(n);
    bus.value = v; bus.dp_in = d; bus.en = en; bus.load = 1'b1;
    if (n == 127) check("load_with_tick", 32'(bus.frame_tick), 32'd1);
    @(negedge clock);
    bus.load = 1'b0;
  endtask

  // Monitor: pops scheduled expectations and watches tick/anode invariants.
  always @(negedge clock) begin
    if (!reset) begin
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc != cyc) begin
          check("sb_missed", 32'(cyc), 32'(e.cyc));
        end else begin
          checks++;
          if ({bus.an, bus.seg, bus.dp} !== {e.an, e.seg, e.dp})
            $display("FAIL display @cyc %0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                     cyc, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
          else passes++;
        end
      end
      if (bus.frame_tick) check("tick_pos", 32'(cyc % 32), 32'd31);
      if (prev_tick) check("tick_width", 32'(bus.frame_tick), 32'd0);
      prev_tick = bus.frame_tick;
      if ($countones(~bus.an) > 1) onehot_viol++;
      if (epoch == 0 && cyc >= 96 && cyc <= 127 &&
          !(bus.an inside {4'b1110, 4'b1011, 4'b1111})) mask_viol++;
    end else begin
      prev_tick = 1'b0;
    end
  end

  initial begin
    checks = 0; passes = 0; onehot_viol = 0; mask_viol = 0; epoch = 0; prev_tick = 1'b0;
    reset = 1'b1;
    bus.value = '0; bus.dp_in = '0; bus.en = '0; bus.load = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_dp", 32'(bus.dp), 32'd1);
    check("rst_tick", 32'(bus.frame_tick), 32'd0);

    // Frame 0 blank (shadow empty); frame 1 shows 1A3F, frame 2 still 1A3F.
    exp_at(2,   4'b1111, S_OFF, 1'b1);
    exp_at(26,  4'b1111, S_OFF, 1'b1);
    exp_at(32,  4'b1111, S_OFF, 1'b1);
    exp_at(33,  4'b1111, S_OFF, 1'b1);
    exp_at(34,  4'b1110, 7'b0001110, 1'b1);
    exp_at(39,  4'b1110, 7'b0001110, 1'b1);
    exp_at(40,  4'b1111, S_OFF, 1'b1);
    exp_at(41,  4'b1111, S_OFF, 1'b1);
    exp_at(42,  4'b1101, 7'b0110000, 1'b1);
    exp_at(50,  4'b1011, 7'b0001000, 1'b0);
    exp_at(58,  4'b0111, 7'b1111001, 1'b1);
    exp_at(63,  4'b0111, 7'b1111001, 1'b1);
    exp_at(66,  4'b1110, 7'b0001110, 1'b1);
    // Frame 3: last of two loads (2222), en=0101.
    exp_at(98,  4'b1110, 7'b0100100, 1'b1);
    exp_at(103, 4'b1110, 7'b0100100, 1'b1);
    exp_at(104, 4'b1111, S_OFF, 1'b1);
    exp_at(106, 4'b1111, S_OFF, 1'b1);
    exp_at(111, 4'b1111, S_OFF, 1'b1);
    exp_at(114, 4'b1011, 7'b0100100, 1'b1);
    exp_at(122, 4'b1111, S_OFF, 1'b1);
    exp_at(127, 4'b1111, S_OFF, 1'b1);
    // Frames 4..7: bypassed 5555 wins over pending 7777 and stays.
    exp_at(130, 4'b1110, 7'b0010010, 1'b1);
    exp_at(138, 4'b1101, 7'b0010010, 1'b1);
    exp_at(146, 4'b1011, 7'b0010010, 1'b1);
    exp_at(154, 4'b0111, 7'b0010010, 1'b1);
    exp_at(162, 4'b1110, 7'b0010010, 1'b1);
    exp_at(194, 4'b1110, 7'b0010010, 1'b1);
    exp_at(244, 4'b1011, 7'b0010010, 1'b1);

    reset = 1'b0;
    load_at(8,   16'h1A3F, 4'b0100, 4'b1111);
    load_at(70,  16'h1111, 4'b0000, 4'b0101);
    load_at(80,  16'h2222, 4'b0000, 4'b0101);
    load_at(100, 16'h7777, 4'b0000, 4'b1111);
    load_at(127, 16'h5555, 4'b0000, 4'b1111);
    load_at(236, 16'h9999, 4'b1111, 4'b1111);

    // Asynchronous reset while digit 2 is driving.
    wait_cyc(244);
    #1 reset = 1'b1;
    #1;
    check("midrst_an", 32'(bus.an), 32'hF);
    check("midrst_seg", 32'(bus.seg), 32'h7F);
    check("midrst_dp", 32'(bus.dp), 32'd1);
    check("midrst_tick", 32'(bus.frame_tick), 32'd0);
    check("sb_empty_before_rst", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clock);

    // Pending 9999 must be gone: nothing shows in the next frame either.
    epoch = 1;
    exp_at(2,  4'b1111, S_OFF, 1'b1);
    exp_at(34, 4'b1111, S_OFF, 1'b1);
    exp_at(36, 4'b1111, S_OFF, 1'b1);
    exp_at(50, 4'b1111, S_OFF, 1'b1);
    reset = 1'b0;

    while (sb.size() != 0 && cyc < 70) @(negedge clock);
    check("sb_drain", 32'(sb.size()), 32'd0);
    check("an_onehot", 32'(onehot_viol), 32'd0);
    check("en_mask", 32'(mask_viol), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
